// File: rtl/sr_latch.sv
// -----------------------------------------------------------------------------
// sr_latch
//   Clocked model of a bank of WIDTH independent NOR-style SR cells with
//   complementary outputs. The S=R=1 ("forbidden") combination produces a
//   deterministic, flagged result selected by INVALID_MODE instead of an
//   unknown value.
//
// Parameters
//   WIDTH         number of independent cells (bit i of every port = cell i)
//   INVALID_MODE  S=R=1 handling: 0 = NOR (q=0,qb=0), 1 = set-dominant,
//                 2 = reset-dominant
//
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset (q=0, qb=1, invalid=0)
//   s        in   WIDTH  set request per cell, sampled on clk
//   r        in   WIDTH  reset request per cell, sampled on clk
//   q        out  WIDTH  registered latch state
//   qb       out  WIDTH  registered complement (both 0 in NOR forbidden state)
//   invalid  out  WIDTH  high while the cell holds an S=R=1 result
// -----------------------------------------------------------------------------
module sr_latch #(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned INVALID_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] invalid
);

  typedef enum logic [1:0] {
    INV_NOR = 2'd0,
    INV_SET = 2'd1,
    INV_RST = 2'd2
  } inv_mode_e;

  localparam logic [1:0] MODE_BITS = INVALID_MODE[1:0];
  localparam inv_mode_e  MODE      = inv_mode_e'(MODE_BITS);

  logic [WIDTH-1:0] q_d,       q_q;
  logic [WIDTH-1:0] qb_d,      qb_q;
  logic [WIDTH-1:0] invalid_d, invalid_q;

  always_comb begin
    q_d       = q_q;
    qb_d      = qb_q;
    invalid_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      unique case ({s[i], r[i]})
        // Hold keeps q; forcing qb to ~q both preserves valid states and
        // resolves a NOR forbidden state (q=qb=0) to q=0, qb=1.
        2'b00: begin
          q_d[i]  = q_q[i];
          qb_d[i] = ~q_q[i];
        end
        2'b10: begin
          q_d[i]  = 1'b1;
          qb_d[i] = 1'b0;
        end
        2'b01: begin
          q_d[i]  = 1'b0;
          qb_d[i] = 1'b1;
        end
        2'b11: begin
          invalid_d[i] = 1'b1;
          case (MODE)
            INV_SET: begin
              q_d[i]  = 1'b1;
              qb_d[i] = 1'b0;
            end
            INV_RST: begin
              q_d[i]  = 1'b0;
              qb_d[i] = 1'b1;
            end
            default: begin
              q_d[i]  = 1'b0;
              qb_d[i] = 1'b0;
            end
          endcase
        end
        default: begin
          q_d[i]  = q_q[i];
          qb_d[i] = qb_q[i];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q       <= '0;
      qb_q      <= '1;
      invalid_q <= '0;
    end else begin
      q_q       <= q_d;
      qb_q      <= qb_d;
      invalid_q <= invalid_d;
    end
  end

  assign q       = q_q;
  assign qb      = qb_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_sr_latch.sv
// -----------------------------------------------------------------------------
// tb_sr_latch
//   Self-checking bench for sr_latch. Three WIDTH=1 instances (one per
//   INVALID_MODE) share s1/r1; a WIDTH=4 mode-0 instance takes s4/r4.
//   Expected results come from a behavioural cell model and are queued when
//   stimulus is driven, then popped and compared one cycle later.
// -----------------------------------------------------------------------------
module tb_sr_latch;

  logic       clk    = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n;
  logic       s1, r1;
  logic [3:0] s4, r4;

  logic       q_m0, qb_m0, inv_m0;
  logic       q_m1, qb_m1, inv_m1;
  logic       q_m2, qb_m2, inv_m2;
  logic [3:0] q_w4, qb_w4, inv_w4;

  sr_latch #(.WIDTH(1), .INVALID_MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .q(q_m0), .qb(qb_m0), .invalid(inv_m0));
  sr_latch #(.WIDTH(1), .INVALID_MODE(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .q(q_m1), .qb(qb_m1), .invalid(inv_m1));
  sr_latch #(.WIDTH(1), .INVALID_MODE(2)) u_m2 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .q(q_m2), .qb(qb_m2), .invalid(inv_m2));
  sr_latch #(.WIDTH(4), .INVALID_MODE(0)) u_w4 (
    .clk(clk), .rst_n(rst_n), .s(s4), .r(r4), .q(q_w4), .qb(qb_w4), .invalid(inv_w4));

  initial forever #5 if (clk_en) clk = ~clk;

  logic [3:0] act_q[4], act_qb[4], act_inv[4];
  always_comb begin
    act_q[0] = {3'b000, q_m0}; act_qb[0] = {3'b000, qb_m0}; act_inv[0] = {3'b000, inv_m0};
    act_q[1] = {3'b000, q_m1}; act_qb[1] = {3'b000, qb_m1}; act_inv[1] = {3'b000, inv_m1};
    act_q[2] = {3'b000, q_m2}; act_qb[2] = {3'b000, qb_m2}; act_inv[2] = {3'b000, inv_m2};
    act_q[3] = q_w4;           act_qb[3] = qb_w4;           act_inv[3] = inv_w4;
  end

  typedef struct {
    int         dut;
    logic [3:0] q;
    logic [3:0] qb;
    logic [3:0] inv;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         mode_of[4] = '{0, 1, 2, 0};
  logic [3:0] mask_of[4] = '{4'h1, 4'h1, 4'h1, 4'hF};
  logic [3:0] mq[4], mqb[4];

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k]  = 4'h0;
      mqb[k] = mask_of[k];
    end
  endtask

  // Drive one set of inputs and queue the outcome expected after the next edge.
  task automatic drive_push(input logic a, input logic b,
                            input logic [3:0] c, input logic [3:0] d);
    logic [3:0] sv, rv, nq, nqb, ni;
    exp_t e;
    s1 = a; r1 = b; s4 = c; r4 = d;
    for (int k = 0; k < 4; k++) begin
      sv = (k == 3) ? c : {3'b000, a};
      rv = (k == 3) ? d : {3'b000, b};
      for (int i = 0; i < 4; i++) begin
        ni[i] = 1'b0;
        case ({sv[i], rv[i]})
          2'b00: begin
            if (!mq[k][i] && !mqb[k][i]) begin
              nq[i] = 1'b0; nqb[i] = 1'b1;
            end else begin
              nq[i] = mq[k][i]; nqb[i] = mqb[k][i];
            end
          end
          2'b10: begin nq[i] = 1'b1; nqb[i] = 1'b0; end
          2'b01: begin nq[i] = 1'b0; nqb[i] = 1'b1; end
          default: begin
            ni[i] = 1'b1;
            if (mode_of[k] == 1)      begin nq[i] = 1'b1; nqb[i] = 1'b0; end
            else if (mode_of[k] == 2) begin nq[i] = 1'b0; nqb[i] = 1'b1; end
            else                      begin nq[i] = 1'b0; nqb[i] = 1'b0; end
          end
        endcase
      end
      mq[k]  = nq & mask_of[k];
      mqb[k] = nqb & mask_of[k];
      e.dut = k; e.q = mq[k]; e.qb = mqb[k]; e.inv = ni & mask_of[k];
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b1;
    s1 = 1'b1; r1 = 1'b0; s4 = 4'hF; r4 = 4'h0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (act_q[k] !== 4'h0 || act_qb[k] !== mask_of[k] || act_inv[k] !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_async dut%0d: q/qb/inv got %b/%b/%b want %b/%b/%b",
                 k, act_q[k], act_qb[k], act_inv[k], 4'h0, mask_of[k], 4'h0);
      end
    end
    model_reset();
    rst_n = 1'b1;
    #1 clk_en = 1'b1;
    for (int n = 0; n < 3; n++) begin
      drive_push(1'b0, 1'b0, 4'h0, 4'h0);
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (act_q[e.dut] !== e.q || act_qb[e.dut] !== e.qb || act_inv[e.dut] !== e.inv) begin
          n_fail++;
          $display("FAIL reset_hold dut%0d step%0d: q/qb/inv got %b/%b/%b want %b/%b/%b",
                   e.dut, n, act_q[e.dut], act_qb[e.dut], act_inv[e.dut], e.q, e.qb, e.inv);
        end
      end
    end
  endtask

  task automatic test_set_hold();
    logic [1:0] t1[3] = '{2'b10, 2'b00, 2'b00};
    logic [3:0] ts[3] = '{4'hF, 4'h0, 4'h0};
    exp_t e;
    for (int n = 0; n < 3; n++) begin
      drive_push(t1[n][1], t1[n][0], ts[n], 4'h0);
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (act_q[e.dut] !== e.q || act_qb[e.dut] !== e.qb || act_inv[e.dut] !== e.inv) begin
          n_fail++;
          $display("FAIL set_hold dut%0d step%0d: q/qb/inv got %b/%b/%b want %b/%b/%b",
                   e.dut, n, act_q[e.dut], act_qb[e.dut], act_inv[e.dut], e.q, e.qb, e.inv);
        end
      end
    end
  endtask

  task automatic test_reset_set();
    logic [1:0] t1[2] = '{2'b01, 2'b10};
    logic [3:0] ts[2] = '{4'h0, 4'h5};
    logic [3:0] tr[2] = '{4'hF, 4'h0};
    exp_t e;
    for (int n = 0; n < 2; n++) begin
      drive_push(t1[n][1], t1[n][0], ts[n], tr[n]);
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (act_q[e.dut] !== e.q || act_qb[e.dut] !== e.qb || act_inv[e.dut] !== e.inv) begin
          n_fail++;
          $display("FAIL reset_set dut%0d step%0d: q/qb/inv got %b/%b/%b want %b/%b/%b",
                   e.dut, n, act_q[e.dut], act_qb[e.dut], act_inv[e.dut], e.q, e.qb, e.inv);
        end
      end
    end
  endtask

  // 11 -> 10 -> 11 -> 00 -> 11 -> 01 on every mode at once.
  task automatic test_invalid_modes();
    logic [1:0] t1[6] = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b11, 2'b01};
    exp_t e;
    for (int n = 0; n < 6; n++) begin
      drive_push(t1[n][1], t1[n][0], {4{t1[n][1]}}, {4{t1[n][0]}});
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (act_q[e.dut] !== e.q || act_qb[e.dut] !== e.qb || act_inv[e.dut] !== e.inv) begin
          n_fail++;
          $display("FAIL invalid_modes dut%0d step%0d: q/qb/inv got %b/%b/%b want %b/%b/%b",
                   e.dut, n, act_q[e.dut], act_qb[e.dut], act_inv[e.dut], e.q, e.qb, e.inv);
        end
      end
    end
  endtask

  task automatic test_wide();
    exp_t e;
    // Start from reset state so the untouched cell 3 holds q=0, qb=1.
    rst_n = 1'b0; #1; rst_n = 1'b1; model_reset();
    for (int n = 0; n < 3; n++) begin
      case (n)
        0:       drive_push(1'b1, 1'b1, 4'b0101, 4'b0011);
        1:       drive_push(1'b0, 1'b0, 4'b0000, 4'b0000);
        default: drive_push(1'b1, 1'b0, 4'b1010, 4'b0000);
      endcase
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (act_q[e.dut] !== e.q || act_qb[e.dut] !== e.qb || act_inv[e.dut] !== e.inv) begin
          n_fail++;
          $display("FAIL wide dut%0d step%0d: q/qb/inv got %b/%b/%b want %b/%b/%b",
                   e.dut, n, act_q[e.dut], act_qb[e.dut], act_inv[e.dut], e.q, e.qb, e.inv);
        end
      end
      if (n == 0) begin
        n_checks++;
        if (q_w4 !== 4'b0100 || qb_w4 !== 4'b1010 || inv_w4 !== 4'b0001) begin
          n_fail++;
          $display("FAIL wide_literal: q/qb/inv got %b/%b/%b want 0100/1010/0001",
                   q_w4, qb_w4, inv_w4);
        end
      end
    end
    // Mid-sequence reset with inputs still requesting set.
    s1 = 1'b1; r1 = 1'b0; s4 = 4'hF; r4 = 4'h0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (act_q[k] !== 4'h0 || act_qb[k] !== mask_of[k] || act_inv[k] !== 4'h0) begin
        n_fail++;
        $display("FAIL mid_reset dut%0d: q/qb/inv got %b/%b/%b want %b/%b/%b",
                 k, act_q[k], act_qb[k], act_inv[k], 4'h0, mask_of[k], 4'h0);
      end
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int n = 0; n < 24; n++) begin
      drive_push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom()), 4'($urandom()));
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (act_q[e.dut] !== e.q || act_qb[e.dut] !== e.qb || act_inv[e.dut] !== e.inv) begin
          n_fail++;
          $display("FAIL back_to_back dut%0d step%0d: q/qb/inv got %b/%b/%b want %b/%b/%b",
                   e.dut, n, act_q[e.dut], act_qb[e.dut], act_inv[e.dut], e.q, e.qb, e.inv);
        end
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    s1 = 1'b0; r1 = 1'b0; s4 = 4'h0; r4 = 4'h0;
    test_reset();
    test_set_hold();
    test_reset_set();
    test_invalid_modes();
    test_wide();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
